// File: rtl/layer_sequencer_if.sv
// layer_sequencer_if: start/done handshake and layer configuration
// bundle between the sequencer and the accelerator front end.
interface layer_sequencer_if;
  logic        start;
  logic        abort;
  logic        done;
  logic        go;
  logic [2:0]  layer_index;
  logic [31:0] data_address;
  logic [31:0] data_size;
  logic [31:0] weight_address;
  logic [31:0] weight_size;
  logic [31:0] result_address;
  logic [31:0] result_size;
  logic        busy;
  logic        all_done;
  logic        error;
  logic [31:0] total_cycles;

  modport master (
    input  start, abort, done,
    output go, layer_index,
    output data_address, data_size,
    output weight_address, weight_size,
    output result_address, result_size,
    output busy, all_done, error,
    output total_cycles
  );

  modport slave (
    output start, abort, done,
    input  go, layer_index,
    input  data_address, data_size,
    input  weight_address, weight_size,
    input  result_address, result_size,
    input  busy, all_done, error,
    input  total_cycles
  );
endinterface

// File: rtl/layer_sequencer.sv
// layer_sequencer: walks the fixed five-layer table, pulsing go
// per layer and waiting for done, with gap, timeout and abort.
module layer_sequencer #(
  parameter int unsigned NUM_LAYERS     = 5,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input logic          clk,
  input logic          rstn,
  layer_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_GO,
    S_WAIT,
    S_GAP,
    S_FINISH
  } state_t;

  typedef struct packed {
    logic [31:0] da;
    logic [31:0] ds;
    logic [31:0] wa;
    logic [31:0] ws;
    logic [31:0] ra;
    logic [31:0] rs;
  } cfg_t;

  localparam logic [2:0] LAST =
    3'(NUM_LAYERS - 1);
  localparam logic [31:0] GAP_LAST =
    32'(GAP_CYCLES - 1);
  localparam logic [31:0] TMO_LAST =
    32'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  layer_q, layer_d;
  logic [31:0] wcnt_q, wcnt_d;
  logic [31:0] gcnt_q, gcnt_d;
  logic [31:0] tot_q, tot_d;
  logic        err_q, err_d;
  cfg_t        cfg_q;

  function automatic cfg_t rom(
    input logic [2:0] l
  );
    cfg_t c;
    c = '0;
    case (l)
      3'd0: begin
        c.ds = 32'd1764;
        c.ws = 32'd40;
        c.rs = 32'd6400;
      end
      3'd1: begin
        c.ds = 32'd6400;
        c.rs = 32'd1600;
      end
      3'd2: begin
        c.ds = 32'd1600;
        c.wa = 32'd40;
        c.ws = 32'd148;
        c.rs = 32'd1296;
      end
      3'd3: begin
        c.ds = 32'd1296;
        c.rs = 32'd324;
      end
      3'd4: begin
        c.ds = 32'd324;
        c.wa = 32'd188;
        c.ws = 32'd3250;
        c.rs = 32'd10;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state, counters and sticky error.
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    wcnt_d  = wcnt_q;
    gcnt_d  = gcnt_q;
    err_d   = err_q;
    tot_d   = tot_q;
    if (state_q != S_IDLE && tot_q != '1)
      tot_d = tot_q + 32'd1;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_SETUP;
          layer_d = '0;
          err_d   = 1'b0;
          tot_d   = '0;
        end
      end
      S_SETUP: begin
        state_d = S_GO;
        wcnt_d  = '0;
      end
      S_GO: state_d = S_WAIT;
      S_WAIT: begin
        wcnt_d = wcnt_q + 32'd1;
        if (bus.done) begin
          if (layer_q == LAST) begin
            state_d = S_FINISH;
          end else if (GAP_CYCLES == 0) begin
            state_d = S_SETUP;
            layer_d = layer_q + 3'd1;
          end else begin
            state_d = S_GAP;
            gcnt_d  = '0;
          end
        end else if (TIMEOUT_CYCLES != 0 &&
                     wcnt_q == TMO_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_GAP: begin
        if (gcnt_q == GAP_LAST) begin
          state_d = S_SETUP;
          layer_d = layer_q + 3'd1;
        end else begin
          gcnt_d = gcnt_q + 32'd1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (bus.abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      err_d   = err_q;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      layer_q <= '0;
      wcnt_q  <= '0;
      gcnt_q  <= '0;
      tot_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      wcnt_q  <= wcnt_d;
      gcnt_q  <= gcnt_d;
      tot_q   <= tot_d;
      err_q   <= err_d;
    end
  end

  // Latch the table entry while in SETUP.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      cfg_q <= '0;
    else if (state_q == S_SETUP)
      cfg_q <= rom(layer_q);
  end

  assign bus.go             = (state_q == S_GO);
  assign bus.all_done       = (state_q == S_FINISH);
  assign bus.busy           = (state_q != S_IDLE);
  assign bus.layer_index    = layer_q;
  assign bus.error          = err_q;
  assign bus.total_cycles   = tot_q;
  assign bus.data_address   = cfg_q.da;
  assign bus.data_size      = cfg_q.ds;
  assign bus.weight_address = cfg_q.wa;
  assign bus.weight_size    = cfg_q.ws;
  assign bus.result_address = cfg_q.ra;
  assign bus.result_size    = cfg_q.rs;

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed bench with a done responder,
// a go/all_done monitor and hand-computed expectations.
module tb_layer_sequencer;

  logic clk;
  logic rstn;

  layer_sequencer_if bus();

  layer_sequencer #(
    .NUM_LAYERS(5),
    .GAP_CYCLES(2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk;
  int nerr;

  int unsigned T [5][6] = '{
    '{0, 1764, 0,   40,   0, 6400},
    '{0, 6400, 0,   0,    0, 1600},
    '{0, 1600, 40,  148,  0, 1296},
    '{0, 1296, 0,   0,    0, 324},
    '{0, 324,  188, 3250, 0, 10}
  };

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d",
               tag, got, exp);
    end
  endtask

  int mode;
  int cyc;
  int go_cnt;
  int ad_cnt;
  int busy_cnt;
  int last_go;
  int wcnt;
  int exp_layer;
  int exp_gap;
  int exp_total;
  int abort_at;
  bit armed;
  bit prev_go;
  bit pend;
  bit b2b;
  bit start_req;
  bit spur_req;
  bit chk_err_clr;
  bit tmo_watch;

  // Clocked responder and monitor, sampled 1ns after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rstn) begin
        armed    = 1'b0;
        bus.done = 1'b0;
        prev_go  = 1'b0;
      end else begin
        if (bus.abort) begin
          chk("abort_idle", bus.busy, 0);
          chk("abort_go", bus.go, 0);
          bus.abort = 1'b0;
        end
        if (bus.start) begin
          bus.start = 1'b0;
          if (chk_err_clr) begin
            chk("err_clear", bus.error, 0);
            chk_err_clr = 1'b0;
          end
        end
        if (bus.busy) busy_cnt++;
        if (bus.go) begin
          chk("go_width", prev_go, 0);
          chk("layer_seq", bus.layer_index,
              exp_layer);
          chk("d_addr", bus.data_address,
              T[exp_layer][0]);
          chk("d_size", bus.data_size,
              T[exp_layer][1]);
          chk("w_addr", bus.weight_address,
              T[exp_layer][2]);
          chk("w_size", bus.weight_size,
              T[exp_layer][3]);
          chk("r_addr", bus.result_address,
              T[exp_layer][4]);
          chk("r_size", bus.result_size,
              T[exp_layer][5]);
          if (exp_layer == 0)
            chk("tot_restart",
                bus.total_cycles, 1);
          else
            chk("go_spacing", cyc - last_go,
                exp_gap);
          exp_layer = (exp_layer + 1) % 5;
          go_cnt++;
          last_go = cyc;
          armed   = 1'b1;
          wcnt    = 0;
        end
        prev_go = bus.go;
        if (pend) begin
          chk("run_total", bus.total_cycles,
              exp_total);
          chk("busy_fall", bus.busy, 0);
          pend = 1'b0;
          if (b2b) begin
            bus.start = 1'b1;
            exp_layer = 0;
            b2b       = 1'b0;
          end
        end
        if (bus.all_done) begin
          chk("last_layer", bus.layer_index, 4);
          ad_cnt++;
          pend = 1'b1;
        end
        if (tmo_watch && bus.error) begin
          chk("tmo_latency", cyc - last_go, 17);
          chk("tmo_busy", bus.busy, 0);
          chk("tmo_total", bus.total_cycles, 18);
          tmo_watch = 1'b0;
        end
        case (mode)
          0: bus.done = 1'b0;
          2: bus.done = 1'b1;
          default: begin
            if (bus.go) begin
              bus.done = 1'b0;
            end else if (armed) begin
              wcnt++;
              if (wcnt == 10) begin
                bus.done = 1'b1;
                armed    = 1'b0;
                if (abort_at ==
                    int'(bus.layer_index)) begin
                  bus.abort = 1'b1;
                  abort_at  = -1;
                end
              end else begin
                bus.done = 1'b0;
              end
            end else begin
              bus.done = 1'b0;
            end
          end
        endcase
        if (start_req) begin
          bus.start = 1'b1;
          start_req = 1'b0;
          exp_layer = 0;
        end
        if (spur_req) begin
          bus.start = 1'b1;
          spur_req  = 1'b0;
        end
      end
    end
  end

  task automatic clr_counts();
    go_cnt   = 0;
    ad_cnt   = 0;
    busy_cnt = 0;
  endtask

  task automatic wait_go(input int n);
    for (int i = 0; i < 400 && go_cnt < n; i++)
      @(negedge clk);
    chk("wait_go", go_cnt >= n, 1);
  endtask

  task automatic wait_ad(input int n);
    for (int i = 0; i < 600 && ad_cnt < n; i++)
      @(negedge clk);
    chk("wait_all_done", ad_cnt, n);
  endtask

  initial begin
    nchk = 0;
    nerr = 0;
    rstn = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.done  = 1'b0;
    mode = 0;
    cyc = 0;
    last_go = 0;
    wcnt = 0;
    exp_layer = 0;
    exp_gap = 14;
    exp_total = 69;
    abort_at = -1;
    armed = 0;
    prev_go = 0;
    pend = 0;
    b2b = 0;
    start_req = 0;
    spur_req = 0;
    chk_err_clr = 0;
    tmo_watch = 0;
    clr_counts();

    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_go", bus.go, 0);
    chk("rst_err", bus.error, 0);
    chk("rst_dsize", bus.data_size, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Reset asserted mid-WAIT of layer 1.
    mode = 1;
    start_req = 1'b1;
    wait_go(2);
    repeat (4) @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_go", bus.go, 0);
    chk("mid_rst_layer", bus.layer_index, 0);
    chk("mid_rst_dsize", bus.data_size, 0);
    chk("mid_rst_rsize", bus.result_size, 0);
    chk("mid_rst_tot", bus.total_cycles, 0);
    chk("mid_rst_ad", bus.all_done, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (8) @(negedge clk);
    chk("post_rst_idle", bus.busy, 0);
    chk("post_rst_go", go_cnt, 2);

    // Full run followed by a back-to-back run.
    clr_counts();
    mode = 1;
    exp_gap = 14;
    exp_total = 69;
    b2b = 1'b1;
    start_req = 1'b1;
    wait_ad(2);
    repeat (3) @(negedge clk);
    chk("full_gos", go_cnt, 10);
    chk("full_busy", busy_cnt, 138);
    chk("full_err", bus.error, 0);
    chk("hold_layer", bus.layer_index, 4);
    chk("hold_dsize", bus.data_size, 324);
    chk("hold_waddr", bus.weight_address, 188);
    chk("hold_wsize", bus.weight_size, 3250);
    chk("hold_rsize", bus.result_size, 10);

    // Abort together with done in layer 2 WAIT.
    clr_counts();
    abort_at = 2;
    start_req = 1'b1;
    wait_go(3);
    repeat (40) @(negedge clk);
    chk("abort_gos", go_cnt, 3);
    chk("abort_ad", ad_cnt, 0);
    chk("abort_layer", bus.layer_index, 2);
    chk("abort_busy", bus.busy, 0);
    chk("abort_err", bus.error, 0);

    // Timeout with done held low.
    clr_counts();
    mode = 0;
    tmo_watch = 1'b1;
    start_req = 1'b1;
    for (int i = 0; i < 100 && !bus.error; i++)
      @(negedge clk);
    repeat (3) @(negedge clk);
    chk("tmo_error", bus.error, 1);
    chk("tmo_seen", tmo_watch, 0);
    chk("tmo_ad", ad_cnt, 0);
    chk("tmo_gos", go_cnt, 1);

    // done held high, extra start while busy.
    clr_counts();
    mode = 2;
    exp_gap = 5;
    exp_total = 24;
    chk_err_clr = 1'b1;
    start_req = 1'b1;
    wait_go(2);
    spur_req = 1'b1;
    wait_ad(1);
    repeat (20) @(negedge clk);
    chk("spur_gos", go_cnt, 5);
    chk("spur_ad", ad_cnt, 1);
    chk("spur_busy_cnt", busy_cnt, 24);
    chk("spur_idle", bus.busy, 0);
    chk("spur_err", bus.error, 0);

    $display("Result: errors=%0d of %0d checks",
             nerr, nchk);
    $finish;
  end

endmodule
